// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [31:0] DEF_EXC_BASE    = 32'hBFC0_0200;
    localparam logic [31:0] DEF_REFILL_OFF  = 32'h0000_0000;
    localparam logic [31:0] DEF_GENERAL_OFF = 32'h0000_0180;

    // Enable vector: PC plus the four pipeline registers, shallowest first.
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;
    localparam int NUM_EN     = 5;

    // Flush vector: the four pipeline registers only.
    localparam int FL_IF_ID  = 0;
    localparam int FL_ID_EX  = 1;
    localparam int FL_EX_MEM = 2;
    localparam int FL_MEM_WB = 3;
    localparam int NUM_FL    = 4;

    function automatic logic [31:0] exc_target(
        input logic        is_eret,
        input logic        is_refill,
        input logic        exl,
        input logic [31:0] epc,
        input logic [31:0] base,
        input logic [31:0] refill_off,
        input logic [31:0] general_off
    );
        logic [31:0] off;
        off = (is_refill && !exl) ? refill_off : general_off;
        return is_eret ? epc : (base + off);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/strobe bundle between the pipeline datapath and the stall/flush scheduler.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             if_busy;
    logic             except_valid;
    logic             except_is_eret;
    logic             except_is_refill;
    logic             cp0_exl;
    logic [31:0]      cp0_epc;
    logic             en_pc;
    logic             en_if_id;
    logic             en_id_ex;
    logic             en_ex_mem;
    logic             en_mem_wb;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             flush_mem_wb;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             exc_pending;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, if_busy,
               except_valid, except_is_eret, except_is_refill, cp0_exl, cp0_epc,
        input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               redirect_valid, redirect_pc, exc_pending, stall_cycles
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, if_busy,
               except_valid, except_is_eret, except_is_refill, cp0_exl, cp0_epc,
        output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
               redirect_valid, redirect_pc, exc_pending, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_stall_cnt_sat.sv
// Generic saturating up-counter with increment enable; sticks at all-ones.
module stall_cnt_sat #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_r;

    // Count up while enabled, holding once the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler: per-stage enables/flushes, delayed exception redirect, stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_BASE    = DEF_EXC_BASE,
    parameter logic [31:0] REFILL_OFF  = DEF_REFILL_OFF,
    parameter logic [31:0] GENERAL_OFF = DEF_GENERAL_OFF,
    parameter int          CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipe_ctrl_if.slave     bus
);
    state_e             state_r;
    state_e             next_state_s;
    logic [31:0]        target_r;
    logic [31:0]        target_s;
    logic               latch_s;
    logic [NUM_EN-1:0]  en_s;
    logic [NUM_FL-1:0]  flush_s;
    logic               redirect_valid_s;
    logic [31:0]        redirect_pc_s;
    logic [CNT_W-1:0]   cnt_s;

    assign target_s = exc_target(bus.except_is_eret, bus.except_is_refill, bus.cp0_exl,
                                 bus.cp0_epc, EXC_BASE, REFILL_OFF, GENERAL_OFF);

    // FSM state and the redirect target held across an outstanding fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_RUN;
            target_r <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                target_r <= target_s;
            end
        end
    end

    // Next-state and strobe generation; reset level forces the quiescent pattern asynchronously.
    always_comb begin
        next_state_s     = state_r;
        latch_s          = 1'b0;
        en_s             = {NUM_EN{1'b1}};
        flush_s          = {NUM_FL{1'b0}};
        redirect_valid_s = 1'b0;
        redirect_pc_s    = 32'h0000_0000;
        if (!rst) begin
            en_s         = {NUM_EN{1'b0}};
            flush_s      = {NUM_FL{1'b1}};
            next_state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.except_valid) begin
                        // The trapping instruction never issued its access, so stalls are moot.
                        en_s    = {NUM_EN{1'b0}};
                        flush_s = {NUM_FL{1'b1}};
                        if (!bus.if_busy) begin
                            redirect_valid_s = 1'b1;
                            redirect_pc_s    = target_s;
                            en_s[STG_PC]     = 1'b1;
                        end else begin
                            latch_s      = 1'b1;
                            next_state_s = ST_EXC_WAIT;
                        end
                    end else if (bus.stallreq_mem) begin
                        en_s[STG_EX_MEM:STG_PC] = 4'b0000;
                        flush_s[FL_MEM_WB]      = 1'b1;
                    end else if (bus.stallreq_ex) begin
                        en_s[STG_ID_EX:STG_PC] = 3'b000;
                        flush_s[FL_EX_MEM]     = 1'b1;
                    end else if (bus.stallreq_id) begin
                        en_s[STG_IF_ID:STG_PC] = 2'b00;
                        flush_s[FL_ID_EX]      = 1'b1;
                    end else if (bus.stallreq_if) begin
                        en_s[STG_PC]       = 1'b0;
                        flush_s[FL_IF_ID]  = 1'b1;
                    end else begin
                        en_s = {NUM_EN{1'b1}};
                    end
                end
                ST_EXC_WAIT: begin
                    en_s    = {NUM_EN{1'b0}};
                    flush_s = {NUM_FL{1'b1}};
                    if (!bus.if_busy) begin
                        next_state_s = ST_REDIRECT;
                    end else begin
                        next_state_s = ST_EXC_WAIT;
                    end
                end
                ST_REDIRECT: begin
                    en_s             = {NUM_EN{1'b0}};
                    en_s[STG_PC]     = 1'b1;
                    flush_s          = {NUM_FL{1'b1}};
                    redirect_valid_s = 1'b1;
                    redirect_pc_s    = target_r;
                    next_state_s     = ST_RUN;
                end
                default: begin
                    en_s         = {NUM_EN{1'b0}};
                    flush_s      = {NUM_FL{1'b1}};
                    next_state_s = ST_RUN;
                end
            endcase
        end
    end

    stall_cnt_sat #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (~en_s[STG_PC]),
        .count (cnt_s)
    );

    assign bus.en_pc          = en_s[STG_PC];
    assign bus.en_if_id       = en_s[STG_IF_ID];
    assign bus.en_id_ex       = en_s[STG_ID_EX];
    assign bus.en_ex_mem      = en_s[STG_EX_MEM];
    assign bus.en_mem_wb      = en_s[STG_MEM_WB];
    assign bus.flush_if_id    = flush_s[FL_IF_ID];
    assign bus.flush_id_ex    = flush_s[FL_ID_EX];
    assign bus.flush_ex_mem   = flush_s[FL_EX_MEM];
    assign bus.flush_mem_wb   = flush_s[FL_MEM_WB];
    assign bus.redirect_valid = redirect_valid_s;
    assign bus.redirect_pc    = redirect_pc_s;
    assign bus.exc_pending    = (state_r != ST_RUN);
    assign bus.stall_cycles   = cnt_s;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised bench for pipe_ctrl against a stage-depth reference model, with directed anchors.
module tb_pipe_ctrl;
    localparam int TB_CNT_W = 6;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // model state
    bit          m_wait;
    bit          m_redir;
    logic [31:0] m_tgt;
    int          m_cnt;
    bit          m_en_pc;

    pipe_ctrl_if #(.CNT_W(TB_CNT_W)) pif();

    pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] spec_target();
        if (pif.except_is_eret) return pif.cp0_epc;
        if (pif.except_is_refill && !pif.cp0_exl) return 32'hBFC0_0200;
        return 32'hBFC0_0380;
    endfunction

    // Compare every DUT output against the model for the current inputs.
    task automatic check_now();
        logic [4:0]  xen;
        logic [3:0]  xfl;
        logic        xrv;
        logic [31:0] xpc;
        int          d;
        xen = 5'b11111; xfl = 4'b0000; xrv = 1'b0; xpc = 32'h0;
        if (!rst) begin
            m_wait = 0; m_redir = 0; m_tgt = 32'h0; m_cnt = 0;
            xen = 5'b00000; xfl = 4'b1111;
        end else if (m_redir) begin
            xen = 5'b00001; xfl = 4'b1111; xrv = 1'b1; xpc = m_tgt;
        end else if (m_wait) begin
            xen = 5'b00000; xfl = 4'b1111;
        end else if (pif.except_valid) begin
            xfl = 4'b1111;
            xen = pif.if_busy ? 5'b00000 : 5'b00001;
            xrv = !pif.if_busy;
            xpc = pif.if_busy ? 32'h0 : spec_target();
        end else begin
            d = pif.stallreq_mem ? 4 : pif.stallreq_ex ? 3 : pif.stallreq_id ? 2 : pif.stallreq_if ? 1 : 0;
            for (int k = 0; k < 5; k++) xen[k] = (k >= d);
            for (int k = 1; k < 5; k++) xfl[k-1] = (k == d);
        end
        m_en_pc = xen[0];
        cmp("en", {59'd0, pif.en_mem_wb, pif.en_ex_mem, pif.en_id_ex, pif.en_if_id, pif.en_pc}, {59'd0, xen});
        cmp("flush", {60'd0, pif.flush_mem_wb, pif.flush_ex_mem, pif.flush_id_ex, pif.flush_if_id}, {60'd0, xfl});
        cmp("redirect", {31'd0, pif.redirect_valid, pif.redirect_pc}, {31'd0, xrv, xpc});
        cmp("exc_pending", {63'd0, pif.exc_pending}, {63'd0, (rst && (m_wait || m_redir))});
        cmp("stall_cycles", {58'd0, pif.stall_cycles}, 64'(m_cnt));
    endtask

    // Advance the model across one rising edge using the inputs held through it.
    task automatic update_model();
        if (rst) begin
            if (!m_en_pc && m_cnt < CNT_MAX) m_cnt++;
            if (m_redir) m_redir = 0;
            else if (m_wait) begin
                if (!pif.if_busy) begin m_wait = 0; m_redir = 1; end
            end else if (pif.except_valid && pif.if_busy) begin
                m_wait = 1; m_tgt = spec_target();
            end
        end
    endtask

    // Inputs are driven just after a rising edge; check mid-cycle, then cross the next edge.
    task automatic cycle();
        #3;
        check_now();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle();
        pif.stallreq_if = 0; pif.stallreq_id = 0; pif.stallreq_ex = 0; pif.stallreq_mem = 0;
        pif.if_busy = 0; pif.except_valid = 0; pif.except_is_eret = 0;
        pif.except_is_refill = 0; pif.cp0_exl = 0; pif.cp0_epc = 32'h0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        m_wait = 0; m_redir = 0; m_tgt = 32'h0; m_cnt = 0; m_en_pc = 0;
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        cycle();
        cmp("reset_en_pc", {63'd0, pif.en_pc}, 64'd0);
        rst = 1'b1;
        cycle();
        cmp("idle_en_all", {59'd0, pif.en_mem_wb, pif.en_ex_mem, pif.en_id_ex, pif.en_if_id, pif.en_pc}, 64'h1F);
        cmp("idle_cnt", {58'd0, pif.stall_cycles}, 64'd0);

        // ex stall shadows id stall for three cycles
        pif.stallreq_ex = 1; pif.stallreq_id = 1;
        repeat (3) cycle();
        cmp("ex_stall_cnt", {58'd0, pif.stall_cycles}, 64'd3);
        idle();

        // immediate redirects, refill vector then general vector
        pif.except_valid = 1; pif.except_is_refill = 1; pif.cp0_exl = 0;
        #1 cmp("refill_pc", {32'd0, pif.redirect_pc}, 64'hBFC0_0200);
        cycle();
        pif.cp0_exl = 1;
        #1 cmp("general_pc", {32'd0, pif.redirect_pc}, 64'hBFC0_0380);
        cycle();

        // redirect delayed by busy fetch; a second trap during the wait is ignored
        idle(); pif.except_valid = 1; pif.if_busy = 1; pif.cp0_exl = 1;
        cycle();
        pif.except_valid = 0; cycle();
        pif.except_valid = 1; pif.except_is_eret = 1; pif.cp0_epc = 32'hDEAD_0000; cycle();
        pif.except_valid = 0; pif.except_is_eret = 0; cycle();
        pif.if_busy = 0; cycle();
        idle();
        #1 cmp("delayed_pc", {31'd0, pif.redirect_valid, pif.redirect_pc}, {31'd0, 1'b1, 32'hBFC0_0380});
        cycle();

        // ERET beats a concurrent mem stall
        pif.except_valid = 1; pif.except_is_eret = 1; pif.cp0_epc = 32'h8000_1234; pif.stallreq_mem = 1;
        #1 cmp("eret_pc", {32'd0, pif.redirect_pc}, 64'h8000_1234);
        cmp("eret_flush_mem_wb", {63'd0, pif.flush_mem_wb}, 64'd1);
        cycle();

        // reset in the middle of a wait discards the pending redirect
        idle(); pif.except_valid = 1; pif.if_busy = 1; cycle();
        pif.except_valid = 0; cycle();
        rst = 1'b0;
        #1 cmp("async_rst_pending", {63'd0, pif.exc_pending}, 64'd0);
        cycle();
        rst = 1'b1; pif.if_busy = 0;
        repeat (3) cycle();
        cmp("no_redirect_after_rst", {63'd0, pif.redirect_valid}, 64'd0);

        // counter saturation
        pif.stallreq_if = 1;
        repeat (CNT_MAX + 6) cycle();
        cmp("cnt_saturate", {58'd0, pif.stall_cycles}, 64'(CNT_MAX));

        for (int i = 0; i < 3000; i++) begin
            if (!rst) rst = 1'b1;
            else rst = ($urandom_range(0, 299) != 0);
            pif.stallreq_if      = ($urandom_range(0, 3) == 0);
            pif.stallreq_id      = ($urandom_range(0, 3) == 0);
            pif.stallreq_ex      = ($urandom_range(0, 3) == 0);
            pif.stallreq_mem     = ($urandom_range(0, 3) == 0);
            pif.if_busy          = ($urandom_range(0, 1) == 0);
            pif.except_valid     = ($urandom_range(0, 7) == 0);
            pif.except_is_eret   = ($urandom_range(0, 2) == 0);
            pif.except_is_refill = ($urandom_range(0, 1) == 0);
            pif.cp0_exl          = ($urandom_range(0, 1) == 0);
            pif.cp0_epc          = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
